// File: rtl/int_ext_arbiter.sv
// Round-robin arbiter that feeds NREQ requesters into a shared integer
// sign/zero extension unit with a single-register output stage.
// Optional: define INT_EXT_STATS_EN to add the neg_count statistics port.

module int_ext_lane (
  input  logic [1:0]  kind,
  input  logic [15:0] data,
  output logic [31:0] ext,
  output logic        neg
);
  always_comb begin
    case (kind)
      2'd0:    ext = {{24{data[7]}}, data[7:0]};
      2'd1:    ext = {24'd0, data[7:0]};
      2'd2:    ext = {{16{data[15]}}, data};
      default: ext = {16'd0, data};
    endcase
    // only the signed kinds can produce a negative result
    neg = ~kind[0] & ext[31];
  end
endmodule

module int_ext_arbiter #(
  parameter int NREQ = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [2*NREQ-1:0] req_kind,
  input  logic [16*NREQ-1:0] req_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_data,
  output logic [1:0]        out_id
`ifdef INT_EXT_STATS_EN
  ,
  output logic [15:0]       neg_count
`endif
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  id;
    logic        neg;
  } resp_t;

  state_t                 state;
  resp_t                  out_q;
  resp_t                  nxt_resp;
  logic [1:0]             last_grant;
  logic [NREQ-1:0][31:0]  lane_ext;
  logic [NREQ-1:0]        lane_neg;
  logic [NREQ-1:0]        grant_oh;
  logic [1:0]             grant_id;
  logic                   grant_any;
  logic                   can_grant;
  logic                   take;
  logic                   out_fire;
  int                     best_dist;

  for (genvar g = 0; g < NREQ; g++) begin : g_lane
    int_ext_lane u_lane (
      .kind (req_kind[2*g +: 2]),
      .data (req_data[16*g +: 16]),
      .ext  (lane_ext[g]),
      .neg  (lane_neg[g])
    );
  end

  // Pick the valid requester closest after last_grant in circular order.
  always_comb begin
    best_dist = NREQ;
    grant_id  = '0;
    grant_any = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_valid[i] &&
          ((i + 2*NREQ - int'(last_grant) - 1) % NREQ) < best_dist) begin
        best_dist = (i + 2*NREQ - int'(last_grant) - 1) % NREQ;
        grant_id  = 2'(i);
        grant_any = 1'b1;
      end
    end
  end

  always_comb begin
    grant_oh = '0;
    for (int i = 0; i < NREQ; i++)
      grant_oh[i] = grant_any && (grant_id == 2'(i));
  end

  // No acceptance while reset is held, so nothing transfers in that cycle.
  assign can_grant = rst_n && ((state == EMPTY) || out_ready);
  assign req_ready = grant_oh & {NREQ{can_grant}};
  assign take      = |req_ready;
  assign out_fire  = out_valid & out_ready;

  always_comb begin
    nxt_resp    = '0;
    nxt_resp.id = grant_id;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_oh[i]) begin
        nxt_resp.data = lane_ext[i];
        nxt_resp.neg  = lane_neg[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= EMPTY;
      out_valid  <= 1'b0;
      out_q      <= '0;
      last_grant <= 2'(NREQ-1);
    end else begin
      case (state)
        EMPTY: begin
          if (take) begin
            state      <= FULL;
            out_valid  <= 1'b1;
            out_q      <= nxt_resp;
            last_grant <= grant_id;
          end
        end
        FULL: begin
          if (take) begin
            out_q      <= nxt_resp;
            last_grant <= grant_id;
          end else if (out_ready) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= EMPTY;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign out_data = out_q.data;
  assign out_id   = out_q.id;

`ifdef INT_EXT_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      neg_count <= '0;
    else if (out_fire && out_q.neg && neg_count != 16'hFFFF)
      neg_count <= neg_count + 16'd1;
  end
`else
  logic unused_fire;
  assign unused_fire = out_fire ^ out_q.neg;
`endif

endmodule

// File: tb/tb_int_ext_arbiter.sv
// Randomised and directed bench for int_ext_arbiter against a behavioural model.
module tb_int_ext_arbiter;
  localparam int NREQ = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_ready;
  logic [2*NREQ-1:0] req_kind = '0;
  logic [16*NREQ-1:0] req_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [31:0]       out_data;
  logic [1:0]        out_id;
`ifdef INT_EXT_STATS_EN
  logic [15:0]       neg_count;
`endif

  int n_chk = 0, n_pass = 0;

  bit          m_full;
  logic [31:0] m_data;
  int          m_id, m_last, m_cnt;
  bit          m_neg;

  logic [1:0]  ek [4] = '{2'd0, 2'd1, 2'd2, 2'd3};
  logic [15:0] ed [4] = '{16'h00FF, 16'h00FE, 16'hFFFD, 16'hFFFC};
  logic [31:0] ex [4] = '{32'hFFFFFFFF, 32'h000000FE, 32'hFFFFFFFD, 32'h0000FFFC};
  logic [15:0] sd [4] = '{16'h0080, 16'h0080, 16'h8000, 16'h8000};

  always #5 clk = ~clk;

  int_ext_arbiter #(.NREQ(NREQ)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_kind  (req_kind),
    .req_data  (req_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_id    (out_id)
`ifdef INT_EXT_STATS_EN
    ,
    .neg_count (neg_count)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] ext_ref(input logic [1:0] k, input logic [15:0] d);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = d[7:0];
    h = d;
    case (k)
      2'd0:    return int'(b);
      2'd1:    return 32'(d[7:0]);
      2'd2:    return int'(h);
      default: return 32'(d);
    endcase
  endfunction

  function automatic void model_reset();
    m_full = 0; m_data = '0; m_id = 0; m_last = NREQ-1; m_neg = 0; m_cnt = 0;
  endfunction

  task automatic set_req(input int i, input bit v, input logic [1:0] k, input logic [15:0] d);
    req_valid[i]       = v;
    req_kind[2*i +: 2] = k;
    req_data[16*i +: 16] = d;
  endtask

  // Inputs are already driven (after a falling edge); check, clock, check.
  task automatic step();
    logic [NREQ-1:0] exp_rdy;
    int win;
    #1;
    exp_rdy = '0;
    win = -1;
    if (!m_full || out_ready)
      for (int k = 1; k <= NREQ; k++) begin
        int idx;
        idx = (m_last + k) % NREQ;
        if (win < 0 && req_valid[idx]) win = idx;
      end
    if (win >= 0) exp_rdy[win] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    @(posedge clk);
    if (m_full && out_ready && m_neg && m_cnt < 16'hFFFF) m_cnt++;
    if (win >= 0) begin
      m_full = 1;
      m_data = ext_ref(req_kind[2*win +: 2], req_data[16*win +: 16]);
      m_id   = win;
      m_last = win;
      m_neg  = (req_kind[2*win] == 1'b0) && m_data[31];
    end else if (m_full && out_ready) begin
      m_full = 0;
    end
    #1;
    chk("out_valid", 32'(out_valid), 32'(m_full));
    if (m_full) begin
      chk("out_data", out_data, m_data);
      chk("out_id", 32'(out_id), 32'(m_id));
    end
`ifdef INT_EXT_STATS_EN
    chk("neg_count", 32'(neg_count), 32'(m_cnt));
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0; req_valid = '0; out_ready = 0;
    model_reset();
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic drain();
    @(negedge clk);
    req_valid = '0;
    out_ready = 1;
    step();
  endtask

  initial begin
    model_reset();
    req_valid = '1;
    #1;
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_id", 32'(out_id), 32'd0);
`ifdef INT_EXT_STATS_EN
    chk("rst_negcnt", 32'(neg_count), 32'd0);
`endif

    // extension of all four kinds, back to back
    do_reset();
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      out_ready = 1;
      set_req(0, 1, ek[i], ed[i]);
      step();
      chk("ext_kind", out_data, ex[i]);
    end
    drain();

    // round-robin fairness
    do_reset();
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      out_ready = 1;
      set_req(0, 1, 2'd1, 16'(i));
      set_req(1, 1, 2'd3, 16'(i + 16'h100));
      step();
      chk("rr_id", 32'(out_id), 32'(i % 2));
    end
    drain();

    // backpressure: hold, then replace without a bubble
    do_reset();
    out_ready = 1;
    set_req(0, 1, 2'd2, 16'h1234);
    step();
    @(negedge clk);
    set_req(0, 1, 2'd0, 16'h0011);
    set_req(1, 1, 2'd1, 16'h0022);
    out_ready = 0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      step();
      chk("bp_hold", out_data, 32'h00001234);
    end
    @(negedge clk);
    out_ready = 1;
    step();
    chk("bp_valid", 32'(out_valid), 32'd1);
    chk("bp_id", 32'(out_id), 32'd1);
    chk("bp_data", out_data, 32'h00000022);
    drain();
    drain();

    // byte kinds ignore the high byte
    do_reset();
    out_ready = 1;
    set_req(0, 1, 2'd1, 16'hAB80);
    step();
    chk("byte_u_hi", out_data, 32'h00000080);
    @(negedge clk);
    set_req(0, 1, 2'd0, 16'h5580);
    step();
    chk("byte_s_hi", out_data, 32'hFFFFFF80);
    drain();

`ifdef INT_EXT_STATS_EN
    do_reset();
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      out_ready = 1;
      set_req(0, 1, ek[i], sd[i]);
      step();
    end
    drain();
    chk("stats_neg", 32'(neg_count), 32'd2);
`endif

    // randomised traffic
    do_reset();
    for (int c = 0; c < 400; c++) begin
      if (c > 0) @(negedge clk);
      for (int i = 0; i < NREQ; i++)
        set_req(i, $urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), 16'($urandom));
      out_ready = $urandom_range(0, 3) != 0;
      step();
    end

    // asynchronous reset while FULL, checked without any clock edge
    @(negedge clk);
    set_req(0, 1, 2'd0, 16'h00FF);
    out_ready = 0;
    step();
    chk("pre_arst_valid", 32'(out_valid), 32'd1);
    #2;
    rst_n = 0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_data", out_data, 32'd0);
    chk("arst_ready", 32'(req_ready), 32'd0);
    model_reset();
    @(negedge clk);
    req_valid = '0;
    rst_n = 1;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
